descrambler32: RTL and testbench
================================

DESCRAMBLER32 -- requirements
Module: descrambler32

Interface
REQ-001 SHALL have parameter SEED, default 32'hFFFFFFFF: LFSR value loaded at reset.
REQ-002 SHALL have parameter CNT_W, default 16: width of word_count.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port seed_load, input, 1 bit: synchronous request to load seed_val into the LFSR.
REQ-006 SHALL have port seed_val, input, 32 bits: new LFSR seed.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a scrambled word.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-009 SHALL have port in_data, input, 32 bits: scrambled word.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a descrambled word.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes out_data this cycle.
REQ-012 SHALL have port out_data, output, 32 bits: descrambled word.
REQ-013 SHALL have port word_count, output, CNT_W bits: number of words accepted since the last reset or seed load.

Function
REQ-014 SHALL use a Fibonacci LFSR with polynomial x^32+x^22+x^2+x+1; one step is shift left with bit0 = s[31]^s[21]^s[1]^s[0].
REQ-015 SHALL use the current LFSR state as the keystream for each accepted word; out_data = in_data XOR state.
REQ-016 SHALL advance the LFSR by exactly 32 single steps per accepted word, and only on an accepted word.
REQ-017 SHALL accept a word when in_valid && in_ready; in_ready = !seed_load && (!out_valid || out_ready).
REQ-018 SHALL register the result; latency is 1 cycle from acceptance to out_valid.
REQ-019 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid when the word is consumed (out_valid && out_ready) and no new word is accepted in the same cycle.
REQ-021 SHALL sustain one word per cycle with simultaneous consume and accept (full throughput).
REQ-022 SHALL, on seed_load, load seed_val into the LFSR, or 32'h00000001 if seed_val is zero, so the LFSR never locks up.
REQ-023 SHALL, on seed_load, clear word_count and out_valid, discarding any pending output.
REQ-024 SHALL give seed_load priority over in_valid in the same cycle; that input word is not accepted.
REQ-025 SHALL increment word_count by 1 per accepted word, wrapping from all-ones to 0.

Reset
REQ-026 SHALL, while rst is high and independent of clk, force the LFSR to SEED (or 32'h1 if SEED is 0), word_count to 0, out_valid to 0 and out_data to 0.
REQ-027 SHALL drive in_ready low while rst is high.
REQ-028 SHALL, on reset mid-transfer, discard the pending output word without delivering it.

Configuration
REQ-029 SHALL, with DESCRAMBLER32_BYPASS_EN defined, add 1-bit input bypass, sampled on each accepted word: when 1, out_data = in_data, the LFSR does not advance and word_count still increments.
REQ-030 SHALL, without DESCRAMBLER32_BYPASS_EN, omit the bypass port and always descramble.

Structure
REQ-031 SHALL place the polynomial tap constants, the 32-bit word typedef and the default seed in shared package descrambler_pkg.
REQ-032 SHALL implement the 32-step LFSR advance as combinational sub-module lfsr32_adv (state in, state+32 out).

Verification
REQ-033 SHALL cover: after reset with SEED default, in_data=32'h00000000 accepted -> next cycle out_data=32'hFFFFFFFF, word_count=1.
REQ-034 SHALL cover: seed_load with seed_val=32'h0 -> first word 32'h00000000 yields out_data=32'h00000001.
REQ-035 SHALL cover: 64 back-to-back words with out_ready held high -> a word every cycle, output matches a bit-serial reference model, word_count=64.
REQ-036 SHALL cover: out_ready low for 5 cycles with out_valid=1 -> in_ready=0, out_data stable, LFSR unchanged.
REQ-037 SHALL cover: seed_load and in_valid in the same cycle -> word not accepted, out_valid=0 next cycle, word_count=0.
REQ-038 SHALL cover: rst asserted between clock edges while out_valid=1 -> out_valid=0 immediately, and the first word after reset uses keystream SEED.

Source files
------------

// File: rtl/descrambler_pkg.sv
// descrambler_pkg: shared word type, LFSR taps and default seed for descrambler32.
package descrambler_pkg;

    typedef logic [31:0] word_t;

    localparam word_t DEFAULT_SEED = 32'hFFFF_FFFF;
    // Taps for x^32+x^22+x^2+x+1 as bit positions in the shift-left register.
    localparam word_t TAP_MASK = 32'h8020_0003;

    function automatic word_t lfsr_step(input word_t s);
        return {s[30:0], ^(s & TAP_MASK)};
    endfunction

    // The all-zero state is a fixed point, so it is replaced by 1.
    function automatic word_t fix_seed(input word_t s);
        return (s == '0) ? 32'h0000_0001 : s;
    endfunction

endpackage

// File: rtl/lfsr32_adv.sv
// lfsr32_adv: combinational 32-step advance of the descrambler LFSR.
module lfsr32_adv
    import descrambler_pkg::*;
(
    input  word_t state_i,
    output word_t state_o
);

    always_comb begin
        state_o = state_i;
        for (int i = 0; i < 32; i++) state_o = lfsr_step(state_o);
    end

endmodule

// File: rtl/descrambler32.sv
// descrambler32: 32-bit self-synchronised-seed LFSR descrambler with ready/valid handshake.
// Define DESCRAMBLER32_BYPASS_EN to add a per-word bypass input.
module descrambler32
    import descrambler_pkg::*;
#(
    parameter word_t SEED  = DEFAULT_SEED,
    parameter int    CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed_val,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
`ifdef DESCRAMBLER32_BYPASS_EN
    input  logic             bypass,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] word_count
);

    localparam word_t RST_STATE = fix_seed(SEED);

    word_t            lfsr_q, lfsr_d, lfsr_adv;
    word_t            out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, byp;

`ifdef DESCRAMBLER32_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    lfsr32_adv u_adv (
        .state_i (lfsr_q),
        .state_o (lfsr_adv)
    );

    assign in_ready = !rst && !seed_load && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        lfsr_d      = seed_load ? fix_seed(seed_val) : (accept && !byp) ? lfsr_adv : lfsr_q;
        cnt_d       = seed_load ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
        out_valid_d = seed_load ? 1'b0 : accept ? 1'b1 : out_valid_q && !out_ready;
        out_data_d  = accept ? (byp ? in_data : in_data ^ lfsr_q) : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q      <= RST_STATE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_descrambler32.sv
// tb_descrambler32: directed/random checks of descrambler32 against a bit-serial keystream model.
module tb_descrambler32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [31:0] seed_val = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] word_count;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ks, hold, seed;
    int cnt;

    descrambler32 dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed_val   (seed_val),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Reference keystream: 32 single Fibonacci steps with feedback s31^s21^s1^s0.
    function automatic logic [31:0] adv32(input logic [31:0] s);
        for (int k = 0; k < 32; k++) s = (s << 1) | (((s >> 31) ^ (s >> 21) ^ (s >> 1) ^ s) & 32'd1);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        step();
        rst = 1'b0;
        ks = 32'hFFFF_FFFF;
        cnt = 0;

        in_data = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("first_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("first_out_valid", 64'(out_valid), 64'd1);
        chk("first_out_data", 64'(out_data), 64'hFFFF_FFFF);
        chk("first_count", 64'(word_count), 64'd1);
        ks = adv32(ks);

        in_valid = 1'b0; seed = $urandom; seed_val = seed; seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        ks = (seed == 0) ? 32'h1 : seed;
        chk("seed_out_valid", 64'(out_valid), 64'd0);
        chk("seed_count", 64'(word_count), 64'd0);

        in_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            in_data = $urandom;
            #1;
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            step();
            cnt++;
            chk("b2b_out_valid", 64'(out_valid), 64'd1);
            chk("b2b_out_data", 64'(out_data), 64'(in_data ^ ks));
            chk("b2b_count", 64'(word_count), 64'(cnt));
            ks = adv32(ks);
        end
        chk("b2b_final_count", 64'(word_count), 64'd64);

        hold = out_data;
        out_ready = 1'b0;
        in_data = $urandom;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            step();
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_data", 64'(out_data), 64'(hold));
            chk("stall_count", 64'(word_count), 64'd64);
        end
        out_ready = 1'b1;
        step();
        chk("resume_out_data", 64'(out_data), 64'(in_data ^ ks));
        chk("resume_count", 64'(word_count), 64'd65);
        ks = adv32(ks);

        in_valid = 1'b0;
        step();
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        seed_val = 32'h0; seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        ks = 32'h1;
        in_data = 32'h0; in_valid = 1'b1;
        step();
        chk("zero_seed_out", 64'(out_data), 64'h1);
        chk("zero_seed_count", 64'(word_count), 64'd1);
        ks = adv32(ks);

        seed = $urandom | 32'h1; seed_val = seed; seed_load = 1'b1;
        in_data = $urandom; in_valid = 1'b1;
        #1;
        chk("prio_in_ready", 64'(in_ready), 64'd0);
        step();
        seed_load = 1'b0; in_valid = 1'b0;
        ks = seed;
        chk("prio_out_valid", 64'(out_valid), 64'd0);
        chk("prio_count", 64'(word_count), 64'd0);
        in_data = $urandom; in_valid = 1'b1;
        step();
        chk("prio_next_out", 64'(out_data), 64'(in_data ^ ks));
        chk("prio_next_count", 64'(word_count), 64'd1);
        in_valid = 1'b0; out_ready = 1'b0;

        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_count", 64'(word_count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        step();
        rst = 1'b0;
        ks = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        in_data = $urandom; in_valid = 1'b1;
        step();
        chk("post_rst_out", 64'(out_data), 64'(in_data ^ ks));
        chk("post_rst_count", 64'(word_count), 64'd1);
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
